// File: rtl/bp_cacc_coh_req_arbiter.sv
// Round-robin wormhole arbiter that merges tile-side coherence requesters onto one NoC link.
// A header with a non-zero length field locks the link to its requester until the last body flit.
module bp_cacc_coh_req_arbiter #(
  parameter int flit_width_p = 64,
  parameter int len_width_p  = 4,
  parameter int len_offset_p = 0,
  parameter int num_req_p    = 3
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [num_req_p-1:0][flit_width_p-1:0] req_data_i,
  input  logic [num_req_p-1:0]                   req_v_i,
  output logic [num_req_p-1:0]                   req_ready_and_o,
  output logic [flit_width_p-1:0]                link_data_o,
  output logic                                   link_v_o,
  input  logic                                   link_ready_and_i,
  output logic [num_req_p-1:0]                   grant_o,
  output logic                                   locked_o
);

  localparam int idx_width_lp = $clog2(num_req_p);

  typedef enum logic {
    e_idle,
    e_burst
  } state_e;

  state_e                  state_r;
  logic [idx_width_lp-1:0] rr_r;
  logic [idx_width_lp-1:0] lock_idx_r;
  logic [len_width_p-1:0]  cnt_r;

  logic [idx_width_lp-1:0] idle_sel;
  logic [idx_width_lp-1:0] cand_idx;
  logic [idx_width_lp-1:0] sel_idx;
  logic [num_req_p-1:0]    sel_onehot;
  logic [len_width_p-1:0]  hdr_len;
  logic                    any_v;
  logic                    have_sel;
  logic                    link_hs;
  int                      cand;

  function automatic logic [idx_width_lp-1:0] next_idx(input logic [idx_width_lp-1:0] i);
    return (i == idx_width_lp'(num_req_p - 1)) ? '0 : i + 1'b1;
  endfunction

  // Scan from the farthest offset back toward rr_r so the closest valid requester wins.
  always_comb begin
    idle_sel = rr_r;
    cand     = 0;
    cand_idx = '0;
    for (int i = num_req_p - 1; i >= 0; i--) begin
      cand = int'(rr_r) + i;
      if (cand >= num_req_p) cand = cand - num_req_p;
      cand_idx = idx_width_lp'(cand);
      if (req_v_i[cand_idx]) idle_sel = cand_idx;
    end
  end

  always_comb begin
    any_v           = |req_v_i;
    sel_idx         = (state_r == e_burst) ? lock_idx_r : idle_sel;
    have_sel        = (state_r == e_burst) || any_v;
    sel_onehot      = have_sel ? (num_req_p'(1) << sel_idx) : '0;
    link_v_o        = have_sel && req_v_i[sel_idx];
    link_data_o     = req_data_i[sel_idx];
    req_ready_and_o = link_ready_and_i ? sel_onehot : '0;
    grant_o         = sel_onehot;
    locked_o        = (state_r == e_burst);
    link_hs         = link_v_o && link_ready_and_i;
    hdr_len         = link_data_o[len_offset_p +: len_width_p];
  end

  // cnt_r holds body flits still owed; the handshake that sees 1 is the tail.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= e_idle;
      rr_r       <= '0;
      cnt_r      <= '0;
      lock_idx_r <= '0;
    end else begin
      case (state_r)
        e_idle: begin
          if (link_hs) begin
            if (hdr_len == '0) begin
              rr_r <= next_idx(idle_sel);
            end else begin
              state_r    <= e_burst;
              lock_idx_r <= idle_sel;
              cnt_r      <= hdr_len;
            end
          end
        end
        e_burst: begin
          if (link_hs) begin
            cnt_r <= cnt_r - 1'b1;
            if (cnt_r == len_width_p'(1)) begin
              state_r <= e_idle;
              rr_r    <= next_idx(lock_idx_r);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bp_cacc_coh_req_arbiter.sv
// Scoreboard bench for bp_cacc_coh_req_arbiter: per-requester source queues feed the DUT,
// the expected link flit order is queued when packets are created and checked on every link handshake.
module tb_bp_cacc_coh_req_arbiter;

  localparam int NR = 3;
  localparam int FW = 64;

  logic                   clk = 1'b0;
  logic                   reset_i;
  logic [NR-1:0][FW-1:0]  req_data_i;
  logic [NR-1:0]          req_v_i;
  logic [NR-1:0]          req_ready_and_o;
  logic [FW-1:0]          link_data_o;
  logic                   link_v_o;
  logic                   link_ready_and_i;
  logic [NR-1:0]          grant_o;
  logic                   locked_o;

  typedef struct packed {
    logic [1:0]    idx;
    logic [FW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [FW-1:0] q0[$];
  logic [FW-1:0] q1[$];
  logic [FW-1:0] q2[$];
  logic [NR-1:0] en;
  int            checks = 0;
  int            errors = 0;
  int            locked_cycles = 0;
  int            used;

  bp_cacc_coh_req_arbiter #(
    .flit_width_p(FW),
    .len_width_p (4),
    .len_offset_p(0),
    .num_req_p   (NR)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .req_data_i      (req_data_i),
    .req_v_i         (req_v_i),
    .req_ready_and_o (req_ready_and_o),
    .link_data_o     (link_data_o),
    .link_v_o        (link_v_o),
    .link_ready_and_i(link_ready_and_i),
    .grant_o         (grant_o),
    .locked_o        (locked_o)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] mk(input int r, input int seq, input int len);
    return {8'hA0 + 8'(r), 40'h0, 8'(seq), 4'h0, 4'(len)};
  endfunction

  task automatic push_src(input int r, input logic [FW-1:0] d);
    case (r)
      0: q0.push_back(d);
      1: q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endtask

  // Packets must be created in the order the link is expected to carry them.
  task automatic pkt(input int r, input int len, input int seq);
    exp_t e;
    for (int b = 0; b <= len; b++) begin
      e.idx  = 2'(r);
      e.data = (b == 0) ? mk(r, seq, len) : mk(r, seq + b, 15);
      push_src(r, e.data);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_heads();
    req_v_i[0]    = en[0] && (q0.size() > 0);
    req_v_i[1]    = en[1] && (q1.size() > 0);
    req_v_i[2]    = en[2] && (q2.size() > 0);
    req_data_i[0] = (q0.size() > 0) ? q0[0] : '0;
    req_data_i[1] = (q1.size() > 0) ? q1[0] : '0;
    req_data_i[2] = (q2.size() > 0) ? q2[0] : '0;
  endtask

  task automatic cycle();
    exp_t          e;
    logic [NR-1:0] want_grant;
    @(negedge clk);
    if (locked_o) locked_cycles++;
    if (link_v_o && link_ready_and_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_flit got %0h want none", link_data_o);
      end else begin
        e = exp_q.pop_front();
        if (link_data_o !== e.data) begin
          errors++;
          $display("[TB] FAIL link_data got %0h want %0h", link_data_o, e.data);
        end
        checks++;
        want_grant = NR'(1) << e.idx;
        if (grant_o !== want_grant) begin
          errors++;
          $display("[TB] FAIL grant got %b want %b", grant_o, want_grant);
        end
      end
    end
    if (req_v_i[0] && req_ready_and_o[0]) void'(q0.pop_front());
    if (req_v_i[1] && req_ready_and_o[1]) void'(q1.pop_front());
    if (req_v_i[2] && req_ready_and_o[2]) void'(q2.pop_front());
    @(posedge clk);
    #1;
    drive_heads();
  endtask

  task automatic run_until_empty(input int budget, output int n);
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout got %0d left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks += 4;
    if (link_v_o !== 1'b0) begin
      errors++; $display("[TB] FAIL %s_link_v got %b want 0", tag, link_v_o);
    end
    if (req_ready_and_o !== '0) begin
      errors++; $display("[TB] FAIL %s_ready got %b want 000", tag, req_ready_and_o);
    end
    if (grant_o !== '0) begin
      errors++; $display("[TB] FAIL %s_grant got %b want 000", tag, grant_o);
    end
    if (locked_o !== 1'b0) begin
      errors++; $display("[TB] FAIL %s_locked got %b want 0", tag, locked_o);
    end
  endtask

  task automatic test_reset();
    reset_i          = 1'b1;
    en               = '0;
    link_ready_and_i = 1'b1;
    drive_heads();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("in_reset");
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");
    @(posedge clk);
    #1;
    en = '1;
    drive_heads();
  endtask

  task automatic test_round_robin();
    pkt(0, 0, 8'h01); pkt(1, 0, 8'h02); pkt(2, 0, 8'h03);
    pkt(0, 0, 8'h04); pkt(1, 0, 8'h05); pkt(2, 0, 8'h06);
    drive_heads();
    run_until_empty(20, used);
    checks++;
    if (used !== 6) begin
      errors++; $display("[TB] FAIL rr_cycles got %0d want 6", used);
    end
  endtask

  task automatic test_burst();
    pkt(0, 0, 8'h10);
    drive_heads();
    run_until_empty(10, used);
    locked_cycles = 0;
    pkt(1, 3, 8'h20); pkt(2, 0, 8'h30); pkt(0, 0, 8'h40);
    drive_heads();
    run_until_empty(20, used);
    checks += 2;
    if (used !== 6) begin
      errors++; $display("[TB] FAIL burst_cycles got %0d want 6", used);
    end
    if (locked_cycles !== 3) begin
      errors++; $display("[TB] FAIL burst_locked got %0d want 3", locked_cycles);
    end
  endtask

  task automatic test_stall_mid_burst();
    pkt(1, 3, 8'h50); pkt(2, 0, 8'h60); pkt(0, 0, 8'h70);
    drive_heads();
    cycle();
    cycle();
    en = 3'b101;
    drive_heads();
    repeat (2) begin
      @(negedge clk);
      checks += 4;
      if (link_v_o !== 1'b0) begin
        errors++; $display("[TB] FAIL stall_link_v got %b want 0", link_v_o);
      end
      if ((req_ready_and_o & 3'b101) !== 3'b000) begin
        errors++; $display("[TB] FAIL stall_ready got %b want x0x0", req_ready_and_o);
      end
      if (grant_o !== 3'b010) begin
        errors++; $display("[TB] FAIL stall_grant got %b want 010", grant_o);
      end
      if (locked_o !== 1'b1) begin
        errors++; $display("[TB] FAIL stall_locked got %b want 1", locked_o);
      end
      @(posedge clk);
      #1;
    end
    en = '1;
    drive_heads();
    locked_cycles = 0;
    run_until_empty(20, used);
    checks += 2;
    if (used !== 4) begin
      errors++; $display("[TB] FAIL resume_cycles got %0d want 4", used);
    end
    if (locked_cycles !== 2) begin
      errors++; $display("[TB] FAIL resume_locked got %0d want 2", locked_cycles);
    end
  endtask

  task automatic test_link_stall();
    link_ready_and_i = 1'b0;
    pkt(0, 0, 8'h80);
    drive_heads();
    repeat (5) begin
      @(negedge clk);
      checks += 4;
      if (link_v_o !== 1'b1) begin
        errors++; $display("[TB] FAIL lstall_link_v got %b want 1", link_v_o);
      end
      if (grant_o !== 3'b001) begin
        errors++; $display("[TB] FAIL lstall_grant got %b want 001", grant_o);
      end
      if (req_ready_and_o !== 3'b000) begin
        errors++; $display("[TB] FAIL lstall_ready got %b want 000", req_ready_and_o);
      end
      if (locked_o !== 1'b0) begin
        errors++; $display("[TB] FAIL lstall_locked got %b want 0", locked_o);
      end
      @(posedge clk);
      #1;
    end
    link_ready_and_i = 1'b1;
    run_until_empty(5, used);
    checks++;
    if (used !== 1) begin
      errors++; $display("[TB] FAIL lstall_cycles got %0d want 1", used);
    end
  endtask

  task automatic test_reset_mid_burst();
    pkt(1, 3, 8'hA0);
    drive_heads();
    cycle();
    cycle();
    reset_i = 1'b1;
    en      = '0;
    q0.delete(); q1.delete(); q2.delete();
    exp_q.delete();
    drive_heads();
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    @(posedge clk);
    #1;
    en = '1;
    // rr_r must be back at 0, so requester 0 beats requester 2.
    pkt(0, 0, 8'hB0); pkt(2, 0, 8'hC0);
    drive_heads();
    run_until_empty(5, used);
    checks++;
    if (used !== 2) begin
      errors++; $display("[TB] FAIL mid_reset_cycles got %0d want 2", used);
    end
    pkt(2, 0, 8'hD0);
    drive_heads();
    run_until_empty(5, used);
  endtask

  task automatic test_max_len();
    locked_cycles = 0;
    pkt(0, 15, 8'hE0); pkt(1, 0, 8'hF0);
    drive_heads();
    run_until_empty(40, used);
    checks += 2;
    if (used !== 17) begin
      errors++; $display("[TB] FAIL maxlen_cycles got %0d want 17", used);
    end
    if (locked_cycles !== 15) begin
      errors++; $display("[TB] FAIL maxlen_locked got %0d want 15", locked_cycles);
    end
  endtask

  initial begin
    req_v_i          = '0;
    req_data_i       = '0;
    link_ready_and_i = 1'b1;
    reset_i          = 1'b1;
    en               = '0;
    test_reset();
    test_round_robin();
    test_burst();
    test_stall_mid_burst();
    test_link_stall();
    test_reset_mid_burst();
    test_max_len();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
